// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op codes, FSM states and helpers for the RV32M sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_m_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    // DIV, DIVU, REM and REMU occupy the top of the M-op range.
    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Operand magnitude/sign capture and result sign correction/select.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]        i_op,
    input  logic [XLEN-1:0]   i_operand_a,
    input  logic [XLEN-1:0]   i_operand_b,
    output logic [XLEN-1:0]   o_mag_a,
    output logic [XLEN-1:0]   o_mag_b,
    output logic              o_neg_res,
    output logic              o_neg_rem,
    input  logic [4:0]        i_op_q,
    input  logic              i_neg_res_q,
    input  logic              i_neg_rem_q,
    input  logic [2*XLEN-1:0] i_acc,
    output logic [XLEN-1:0]   o_result
);

    logic              w_sa;
    logic              w_sb;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    always_comb begin
        w_sa = ((i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                (i_op == OP_DIV) || (i_op == OP_REM)) && i_operand_a[XLEN-1];
        w_sb = ((i_op == OP_MUL) || (i_op == OP_MULH) ||
                (i_op == OP_DIV) || (i_op == OP_REM)) && i_operand_b[XLEN-1];
        o_mag_a   = w_sa ? -i_operand_a : i_operand_a;
        o_mag_b   = w_sb ? -i_operand_b : i_operand_b;
        o_neg_res = w_sa ^ w_sb;
        o_neg_rem = w_sa;
    end

    // Divide packs {remainder, quotient}; multiply holds the full product.
    always_comb begin
        w_prod = i_neg_res_q ? -i_acc : i_acc;
        w_quot = i_neg_res_q ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
        w_rem  = i_neg_rem_q ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];
        case (i_op_q)
            OP_MUL:                       o_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              o_result = w_quot;
            default:                      o_result = w_rem;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Multi-cycle RV32M multiply/divide sequencer (shift-add / restoring).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_op;
    logic              r_neg_res;
    logic              r_neg_rem;

    logic              w_accept;
    logic              w_div_op;
    logic              w_rem_op;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_result;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg_res;
    logic              w_neg_rem;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN-1:0]   w_fix_result;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .i_op        (i_op),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .o_mag_a     (w_mag_a),
        .o_mag_b     (w_mag_b),
        .o_neg_res   (w_neg_res),
        .o_neg_rem   (w_neg_rem),
        .i_op_q      (r_op),
        .i_neg_res_q (r_neg_res),
        .i_neg_rem_q (r_neg_rem),
        .i_acc       (w_acc_next),
        .o_result    (w_fix_result)
    );

    always_comb begin
        w_accept  = (r_state == ST_IDLE) && i_start && is_m_op(i_op) && !i_flush;
        w_div_op  = is_div_op(i_op);
        w_rem_op  = (i_op == OP_REM) || (i_op == OP_REMU);
        w_b_zero  = (i_operand_b == '0);
        w_ovf     = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                    (i_operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_operand_b == '1);
        w_special = w_div_op && (w_b_zero || w_ovf);
        if (w_b_zero)
            w_special_result = w_rem_op ? i_operand_a : '1;
        else
            w_special_result = w_rem_op ? '0 : i_operand_a;
    end

    // One iteration step: shift-add for multiply, shift-subtract for divide.
    always_comb begin
        w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : {XLEN{1'b0}})};
        w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
        w_ge     = (w_rem_sh >= {1'b0, r_opnd});
        w_sub    = w_rem_sh[XLEN-1:0] - r_opnd;
        if (is_div_op(r_op))
            w_acc_next = w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1}
                              : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (i_flush)             w_state_next = ST_IDLE;
                else if (r_cnt == '0)    w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_result  <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= i_op;
                        r_neg_res <= w_neg_res;
                        r_neg_rem <= w_neg_rem;
                        r_cnt     <= '1;
                        if (w_div_op) begin
                            r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                            r_opnd <= w_mag_b;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                            r_opnd <= w_mag_a;
                        end
                        if (w_special) r_result <= w_special_result;
                    end
                end
                ST_CALC: begin
                    if (!i_flush) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == '0) r_result <= w_fix_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_stall  = w_accept || (r_state == ST_CALC);
    assign o_valid  = (r_state == ST_DONE) && !i_flush;
    assign o_result = r_result;

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M ops that the single-cycle ALU does not implement: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU in the EX stage and implements the datapath as radix-2 shift-add (multiply) and restoring (divide) on unsigned magnitudes, with sign pre/post correction.
- Drives a stall to the hazard unit while busy and returns one result per accepted op, with a valid pulse.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  request; sampled only in IDLE
- i_op  in  5  op code, ALU op encoding: MUL 5'b01011, MULH 5'b01100, MULHSU 5'b01101, MULHU 5'b01110, DIV 5'b01111, DIVU 5'b10000, REM 5'b10001, REMU 5'b10010
- i_operand_a  in  XLEN  multiplicand / dividend (rs1)
- i_operand_b  in  XLEN  multiplier / divisor (rs2)
- i_flush  in  1  abort current op (branch mispredict flush)
- o_busy  out  1  state != IDLE
- o_stall  out  1  combinational: (IDLE & accepted start) | CALC
- o_valid  out  1  one-cycle pulse, result ready
- o_result  out  XLEN  result; held until next o_valid

Behaviour:
- Reset: state IDLE, counter 0, o_valid 0, o_result 0, internal accumulators 0. Reset wins over every other input, including mid-CALC.
- Accept rule: in IDLE, i_start=1 with a valid M op code. Op, operand signs and magnitudes are captured at that edge. i_start with any other op code is ignored; o_stall stays 0.
- States:
  - IDLE -> CALC on normal accept.
  - IDLE -> DONE on a special case.
  - CALC -> DONE after 32 iterations, counter counting 31 down to 0.
  - DONE -> IDLE unconditionally.
- Latency:
  - Normal ops: o_valid high in the cycle after the 33rd edge following the accept edge (1 accept + 32 CALC edges).
  - Special cases: o_valid high in the cycle after the accept edge.
- o_valid is high only in DONE. o_result is registered when entering DONE.
- Signedness:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats a as signed, b as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
  - Core operates on absolute values. Product is negated if signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign.
- Result select: MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32] of the 64-bit signed-corrected product. DIV/DIVU return the quotient. REM/REMU return the remainder.
- Special cases (no iteration, direct to DONE):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend unchanged.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- i_flush: in CALC or DONE, next state is IDLE, o_valid is suppressed for that cycle if in DONE, and o_result is unchanged. In IDLE, a flush coincident with i_start blocks acceptance.
- i_start while not IDLE is ignored. No queueing. The earliest back-to-back accept is in the IDLE cycle following DONE.
- Operand inputs may change after the accept edge without effect.

Decomposition:
- Shared package muldiv_pkg: op-code localparams, matching the ALU op encoding; state enum {IDLE, CALC, DONE}; XLEN constant.
- One sub-module, muldiv_sign_fix (combinational): operand abs/sign capture before iteration and result negation/select after it.
- FSM, counter and shift registers stay in muldiv_seq.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3) -> o_result 0xFFFFFFEB; o_valid exactly 33 edges after accept; o_stall high from the accept cycle through the last CALC cycle.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with o_valid 1 edge after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each 1-edge latency.
- Flush and reset:
  - Start DIVU, assert i_flush on CALC edge 10 -> IDLE next edge, no o_valid, o_result unchanged.
  - Same op with i_reset asserted at edge 10 -> IDLE and all outputs 0.
- Start pulses during CALC and DONE plus an invalid op code (5'b00000) in IDLE -> all ignored. A new MUL accepted in the IDLE cycle right after DONE completes normally.
